mac_array: RTL and testbench
============================

Name: mac_array

Overview:
- Parametrised successor to the fixed 4x4 MAC: computes R[j] = sum over k of A[k]*W[bank][k][j] + C[j] for one input row per accepted beat.
- Weight memory holds NBANK selectable KxJ matrices of signed DW-bit values, loaded through a row-serial load port.
- Two-stage compute pipeline with valid/ready flow control on both sides; sits between the activation buffer and the accumulator/writeback stage of the gcn datapath.

Parameters:
- K, 4, reduction length (input lanes per beat)
- J, 4, output lanes per beat
- DW, 16, signed width of a, c, weights and r
- NBANK, 32, number of weight matrices; bank index width BW = clog2(NBANK)
- FRAC, 0, fractional bits; the full-precision result is arithmetic-shifted right by FRAC before narrowing

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- wl_start  in  1  begin loading bank wl_bank (sampled only in W_IDLE)
- wl_bank  in  BW  bank to load
- wl_v  in  1  row-beat valid
- wl_row  in  J*DW  one weight row W[bank][k][0..J-1]; k increments per beat
- wl_busy  out  1  load in progress
- in_v  in  1  compute request valid
- in_ready  out  1  compute request accepted when in_v && in_ready
- a  in  K*DW  input row A[0..K-1], signed
- bidx  in  BW  bank selected for this beat
- c  in  J*DW  accumulator input, signed
- r_v  out  1  result valid
- r_ready  in  1  downstream accepts when r_v && r_ready
- r  out  J*DW  result lanes, signed

Behaviour:
- Reset: r_v=0, r=0, wl_busy=0, load FSM to W_IDLE, row counter 0, pipeline valids 0. Weight memory contents are not reset (undefined until loaded). Reset mid-load abandons the load; the partially written bank remains partially updated.
- Load FSM: W_IDLE -> W_LOAD on wl_start (latch wl_bank, row_cnt=0, wl_busy=1 next cycle). In W_LOAD each wl_v beat writes row row_cnt and increments it; on the beat with row_cnt==K-1 -> W_IDLE, wl_busy=0 next cycle. wl_start in W_LOAD is ignored. wl_v in W_IDLE is ignored.
- Hazard: in_ready=0 whenever wl_busy && bidx==latched load bank. Compute on other banks proceeds concurrently with loading.
- Pipeline: S1 registers K*J signed products plus c; S2 registers the sum into r. Latency: accept in cycle t -> r_v=1 in cycle t+2 when not stalled. Throughput 1 beat/cycle.
- Flow control: stall when r_v && !r_ready; both stages hold and in_ready=0 (on top of the hazard condition). in_ready = !(r_v && !r_ready) && !hazard. A stage with no valid data is a bubble and never blocks the stage behind it. r and r_v remain stable while stalled.
- Arithmetic: each product is 2*DW bits signed. Sum = sum_k products + (sign-extend(c[j]) << FRAC), in 2*DW+clog2(K)+1 bits (no intermediate overflow). Shift arithmetically right by FRAC (truncate toward -inf). Narrow to DW by taking the low DW bits (two's-complement wrap).
- Same-cycle load write and compute read of different banks: both take effect. A weight write takes effect for beats accepted from the following cycle.

Optional Feature:
- MAC_SATURATE_EN: when defined, narrowing saturates to [-2^(DW-1), 2^(DW-1)-1] and adds output port sat_flag (1 bit), registered alongside r and valid with r_v, set when any lane clipped. When undefined: wrap narrowing, no sat_flag port.

Test Plan:
- Load bank 3 with the identity matrix (diag=1); a={1,2,3,4}, c={10,10,10,10}, bidx=3 -> r={11,12,13,14} exactly 2 cycles after the accept cycle.
- Load bank 0 with all -2; a={100,-50,7,0}, c={0,0,0,5} -> r={-114,-114,-114,-109}.
- Stream 8 back-to-back beats, holding r_ready=0 for cycles 3-5 -> in_ready drops, no beat lost or duplicated, r held stable, results in order.
- Start load of bank 5 and issue in_v with bidx=5 and then bidx=3 -> bidx=5 is held with in_ready=0 until wl_busy falls, bidx=3 is accepted immediately, and bidx=5 then uses the new weights.
- Overflow: weights all 0x7FFF, a all 0x7FFF, c=0 -> without the macro r=low 16 bits of 4*0x3FFF0001 (0x0004); with MAC_SATURATE_EN r=0x7FFF and sat_flag=1.
- Assert reset during W_LOAD after 2 rows -> wl_busy=0 and r_v=0 next cycle; a fresh wl_start is accepted.

Source files
------------

// File: rtl/mac_array.sv
// rtl/mac_array.sv - banked-weight K x J multiply-accumulate array with a two-stage valid/ready pipeline.
// Optional MAC_SATURATE_EN: saturating narrowing plus a registered sat_flag output.
module mac_array #(
    parameter int K     = 4,
    parameter int J     = 4,
    parameter int DW    = 16,
    parameter int NBANK = 32,
    parameter int FRAC  = 0,
    localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wl_start,
    input  logic [BW-1:0]   wl_bank,
    input  logic            wl_v,
    input  logic [J*DW-1:0] wl_row,
    output logic            wl_busy,
    input  logic            in_v,
    output logic            in_ready,
    input  logic [K*DW-1:0] a,
    input  logic [BW-1:0]   bidx,
    input  logic [J*DW-1:0] c,
    output logic            r_v,
    input  logic            r_ready,
    output logic [J*DW-1:0] r
`ifdef MAC_SATURATE_EN
    ,
    output logic            sat_flag
`endif
);

    localparam int RCW = (K > 1) ? $clog2(K) : 1;
    localparam int SW  = 2 * DW + $clog2(K) + 1;

    typedef enum logic {W_IDLE, W_LOAD} wstate_t;

    wstate_t          wstate;
    logic [BW-1:0]    ld_bank;
    logic [RCW-1:0]   row_cnt;

    logic signed [DW-1:0] wmem [NBANK][K][J];

    logic stall;
    logic hazard;
    logic accept;

    logic                   s1_v;
    logic signed [2*DW-1:0] s1_p [K][J];
    logic signed [DW-1:0]   s1_c [J];

    logic signed [SW-1:0] acc [J];
    logic signed [SW-1:0] shf [J];
    logic [J*DW-1:0]      r_next;
    logic                 clip_any;

    always_ff @(posedge clock) begin
        if (reset) begin
            wstate  <= W_IDLE;
            ld_bank <= '0;
            row_cnt <= '0;
            wl_busy <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (wl_start) begin
                        wstate  <= W_LOAD;
                        ld_bank <= wl_bank;
                        row_cnt <= '0;
                        wl_busy <= 1'b1;
                    end
                end
                W_LOAD: begin
                    if (wl_v) begin
                        row_cnt <= row_cnt + RCW'(1);
                        if (row_cnt == RCW'(K - 1)) begin
                            wstate  <= W_IDLE;
                            wl_busy <= 1'b0;
                        end
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Weight storage is deliberately unreset; a bank is undefined until loaded.
    always_ff @(posedge clock) begin
        if (!reset && wstate == W_LOAD && wl_v) begin
            for (int j = 0; j < J; j++) begin
                wmem[ld_bank][row_cnt][j] <= wl_row[j*DW +: DW];
            end
        end
    end

    assign stall    = r_v && !r_ready;
    assign hazard   = wl_busy && (bidx == ld_bank);
    assign in_ready = !stall && !hazard;
    assign accept   = in_v && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v <= 1'b0;
        end else if (!stall) begin
            s1_v <= accept;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            for (int k = 0; k < K; k++) begin
                for (int j = 0; j < J; j++) begin
                    s1_p[k][j] <= (2*DW)'($signed(a[k*DW +: DW])) * (2*DW)'(wmem[bidx][k][j]);
                end
            end
            for (int j = 0; j < J; j++) begin
                s1_c[j] <= c[j*DW +: DW];
            end
        end
    end

`ifdef MAC_SATURATE_EN
    localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`else
    logic unused_hi;
`endif

    // c is pre-scaled by FRAC so it aligns with the fixed-point products.
    always_comb begin
        r_next   = '0;
        clip_any = 1'b0;
`ifndef MAC_SATURATE_EN
        unused_hi = 1'b0;
`endif
        for (int j = 0; j < J; j++) begin
            acc[j] = SW'(s1_c[j]) <<< FRAC;
            for (int k = 0; k < K; k++) begin
                acc[j] = acc[j] + SW'(s1_p[k][j]);
            end
            shf[j] = acc[j] >>> FRAC;
`ifdef MAC_SATURATE_EN
            if (shf[j] > SMAX) begin
                r_next[j*DW +: DW] = SMAX[DW-1:0];
                clip_any           = 1'b1;
            end else if (shf[j] < SMIN) begin
                r_next[j*DW +: DW] = SMIN[DW-1:0];
                clip_any           = 1'b1;
            end else begin
                r_next[j*DW +: DW] = shf[j][DW-1:0];
            end
`else
            r_next[j*DW +: DW] = shf[j][DW-1:0];
            unused_hi          = unused_hi ^ (^shf[j][SW-1:DW]);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v      <= 1'b0;
            r        <= '0;
`ifdef MAC_SATURATE_EN
            sat_flag <= 1'b0;
`endif
        end else if (!stall) begin
            r_v <= s1_v;
            if (s1_v) begin
                r        <= r_next;
`ifdef MAC_SATURATE_EN
                sat_flag <= clip_any;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mac_array.sv
// tb/tb_mac_array.sv - randomized self-checking bench for mac_array against an arithmetic reference model.
module tb_mac_array;

    localparam int K     = 4;
    localparam int J     = 4;
    localparam int DW    = 16;
    localparam int NBANK = 32;
    localparam int FRAC  = 0;
    localparam int BW    = 5;

    logic            clock    = 1'b0;
    logic            reset    = 1'b1;
    logic            wl_start = 1'b0;
    logic [BW-1:0]   wl_bank  = '0;
    logic            wl_v     = 1'b0;
    logic [J*DW-1:0] wl_row   = '0;
    logic            wl_busy;
    logic            in_v     = 1'b0;
    logic            in_ready;
    logic [K*DW-1:0] a        = '0;
    logic [BW-1:0]   bidx     = '0;
    logic [J*DW-1:0] c        = '0;
    logic            r_v;
    logic            r_ready  = 1'b1;
    logic [J*DW-1:0] r;
`ifdef MAC_SATURATE_EN
    logic            sat_flag;
`endif

    mac_array #(.K(K), .J(J), .DW(DW), .NBANK(NBANK), .FRAC(FRAC)) dut (
        .clock(clock), .reset(reset),
        .wl_start(wl_start), .wl_bank(wl_bank), .wl_v(wl_v), .wl_row(wl_row), .wl_busy(wl_busy),
        .in_v(in_v), .in_ready(in_ready), .a(a), .bidx(bidx), .c(c),
        .r_v(r_v), .r_ready(r_ready), .r(r)
`ifdef MAC_SATURATE_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [J*DW-1:0] r;
        logic            sat;
        int              cyc;
        int              stl;
    } exp_t;

    int   mw [NBANK][K][J];
    exp_t sb [$];
    int   cyc       = 0;
    int   stall_cnt = 0;
    int   pop_cnt   = 0;
    logic ld_active = 1'b0;
    int   ld_bank_m = 0;
    int   ld_rows   = 0;
    logic prev_stall = 1'b0;
    logic prev_reset = 1'b0;
    logic [J*DW-1:0] held_r;
    logic [J*DW-1:0] ldrows [K];
    logic done = 1'b0;

    function automatic logic [J*DW-1:0] pk(input int v0, input int v1, input int v2, input int v3);
        return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    // R[j] = sum_k A[k]*W[k][j] + C[j]*2^FRAC, then >>> FRAC, then wrap or clamp.
    function automatic exp_t model(input logic [K*DW-1:0] av, input logic [J*DW-1:0] cv, input int b);
        exp_t   e;
        longint s;
        longint lo;
        longint hi;
        e.r   = '0;
        e.sat = 1'b0;
        e.cyc = 0;
        e.stl = 0;
        lo = -(longint'(1) << (DW - 1));
        hi = (longint'(1) << (DW - 1)) - 1;
        for (int j = 0; j < J; j++) begin
            s = longint'($signed(cv[j*DW +: DW])) * (longint'(1) << FRAC);
            for (int k = 0; k < K; k++) begin
                s += longint'($signed(av[k*DW +: DW])) * longint'(mw[b][k][j]);
            end
            s = s >>> FRAC;
`ifdef MAC_SATURATE_EN
            if (s > hi) begin
                e.r[j*DW +: DW] = hi[DW-1:0];
                e.sat = 1'b1;
            end else if (s < lo) begin
                e.r[j*DW +: DW] = lo[DW-1:0];
                e.sat = 1'b1;
            end else begin
                e.r[j*DW +: DW] = s[DW-1:0];
            end
`else
            e.r[j*DW +: DW] = s[DW-1:0];
`endif
        end
        return e;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (reset) begin
            sb.delete();
            ld_active  = 1'b0;
            prev_stall = 1'b0;
            prev_reset = 1'b1;
        end else begin
            if (prev_reset) begin
                check("rst_r_v", r_v, 1'b0);
                check("rst_busy", wl_busy, 1'b0);
            end
            prev_reset = 1'b0;
            check("busy", wl_busy, ld_active);
            check("in_ready", in_ready, !(r_v && !r_ready) && !(ld_active && bidx == BW'(ld_bank_m)));
            if (prev_stall) begin
                check("hold_v", r_v, 1'b1);
                check("hold_r", r, held_r);
            end
            if (r_v && r_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_r_v", r_v, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("r", r, e.r);
`ifdef MAC_SATURATE_EN
                    check("sat_flag", sat_flag, e.sat);
`endif
                    if (e.stl == stall_cnt) check("latency", cyc - e.cyc, 2);
                    pop_cnt++;
                end
            end
            prev_stall = r_v && !r_ready;
            if (prev_stall) begin
                held_r = r;
                stall_cnt++;
            end
            if (in_v && in_ready) begin
                e     = model(a, c, int'(bidx));
                e.cyc = cyc;
                e.stl = stall_cnt;
                sb.push_back(e);
            end
            if (!ld_active && wl_start) begin
                ld_active = 1'b1;
                ld_bank_m = int'(wl_bank);
                ld_rows   = 0;
            end else if (ld_active && wl_v) begin
                for (int j = 0; j < J; j++) mw[ld_bank_m][ld_rows][j] = int'($signed(wl_row[j*DW +: DW]));
                ld_rows++;
                if (ld_rows == K) ld_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int b);
        wl_start = 1'b1;
        wl_bank  = BW'(b);
        tick();
        wl_start = 1'b0;
        for (int k = 0; k < K; k++) begin
            wl_v   = 1'b1;
            wl_row = ldrows[k];
            tick();
        end
        wl_v = 1'b0;
    endtask

    task automatic rand_rows();
        for (int k = 0; k < K; k++) ldrows[k] = {$urandom, $urandom};
    endtask

    task automatic send(input logic [K*DW-1:0] av, input logic [J*DW-1:0] cv, input int b);
        logic ok;
        ok   = 1'b0;
        in_v = 1'b1;
        a    = av;
        c    = cv;
        bidx = BW'(b);
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
        end
        if (!ok) check("send_timeout", in_ready, 1'b1);
        in_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int banks [5];
        banks = '{0, 3, 5, 7, 9};

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        check("reset_r", r, 64'h0);
        check("reset_in_ready", in_ready, 1'b1);
        tick();

        for (int k = 0; k < K; k++) ldrows[k] = pk(k == 0, k == 1, k == 2, k == 3);
        load(3);
        send(pk(1, 2, 3, 4), pk(10, 10, 10, 10), 3);
        @(negedge clock);
        check("ident_lat1_v", r_v, 1'b0);
        tick();
        @(negedge clock);
        check("ident_lat2_v", r_v, 1'b1);
        check("ident_r", r, pk(11, 12, 13, 14));
        tick();

        for (int k = 0; k < K; k++) ldrows[k] = pk(-2, -2, -2, -2);
        load(0);
        send(pk(100, -50, 7, 0), pk(0, 0, 0, 5), 0);
        tick();
        @(negedge clock);
        check("neg2_r", r, pk(-114, -114, -114, -109));
        tick();

        for (int k = 0; k < K; k++) ldrows[k] = pk(32767, 32767, 32767, 32767);
        load(7);
        send(pk(32767, 32767, 32767, 32767), '0, 7);
        tick();
        @(negedge clock);
`ifdef MAC_SATURATE_EN
        check("ovf_r", r, pk(32767, 32767, 32767, 32767));
        check("ovf_sat", sat_flag, 1'b1);
`else
        check("ovf_r", r, pk(4, 4, 4, 4));
`endif
        tick();

        base = pop_cnt;
        fork
            begin
                for (int n = 0; n < 8; n++) send({$urandom, $urandom}, {$urandom, $urandom}, (n % 2) ? 0 : 3);
            end
            begin
                repeat (3) tick();
                r_ready = 1'b0;
                repeat (3) tick();
                r_ready = 1'b1;
            end
        join
        repeat (5) tick();
        check("stream_cnt", pop_cnt - base, 8);
        check("stream_empty", sb.size(), 0);

        rand_rows();
        wl_start = 1'b1;
        wl_bank  = BW'(5);
        tick();
        wl_start = 1'b0;
        in_v = 1'b1;
        a    = {$urandom, $urandom};
        c    = {$urandom, $urandom};
        bidx = BW'(5);
        wl_v   = 1'b1;
        wl_row = ldrows[0];
        @(negedge clock);
        check("haz_hold", in_ready, 1'b0);
        tick();
        bidx   = BW'(3);
        wl_row = ldrows[1];
        @(negedge clock);
        check("haz_other", in_ready, 1'b1);
        tick();
        bidx = BW'(5);
        for (int k = 2; k < K; k++) begin
            wl_row = ldrows[k];
            @(negedge clock);
            check("haz_hold_late", in_ready, 1'b0);
            tick();
        end
        wl_v = 1'b0;
        @(negedge clock);
        check("haz_release_busy", wl_busy, 1'b0);
        check("haz_release", in_ready, 1'b1);
        tick();
        in_v = 1'b0;
        repeat (4) tick();

        r_ready = 1'b0;
        send({$urandom, $urandom}, {$urandom, $urandom}, 3);
        wl_start = 1'b1;
        wl_bank  = BW'(9);
        tick();
        wl_start = 1'b0;
        wl_v   = 1'b1;
        wl_row = {$urandom, $urandom};
        tick();
        wl_row = {$urandom, $urandom};
        tick();
        wl_v  = 1'b0;
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        r_ready = 1'b1;
        @(negedge clock);
        check("midload_busy", wl_busy, 1'b0);
        check("midload_r_v", r_v, 1'b0);
        tick();
        rand_rows();
        wl_start = 1'b1;
        wl_bank  = BW'(9);
        tick();
        wl_start = 1'b0;
        @(negedge clock);
        check("fresh_busy", wl_busy, 1'b1);
        tick();
        for (int k = 0; k < K; k++) begin
            wl_v   = 1'b1;
            wl_row = ldrows[k];
            tick();
        end
        wl_v = 1'b0;
        tick();

        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    if ($urandom_range(3) == 0) tick();
                    send({$urandom, $urandom}, {$urandom, $urandom}, banks[$urandom_range(4)]);
                end
                done = 1'b1;
            end
            begin
                for (int n = 0; n < 5; n++) begin
                    repeat ($urandom_range(10, 2)) tick();
                    rand_rows();
                    load(banks[$urandom_range(4)]);
                end
            end
            begin
                while (!done) begin
                    r_ready = ($urandom_range(3) != 0);
                    tick();
                end
            end
        join
        r_ready = 1'b1;
        repeat (6) tick();
        check("random_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
